// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: data word, RAM handshake state
// and the arbiter FSM encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IGRANT = 2'b01,
      DGRANT = 2'b10
   } arb_state_t;

endpackage

// File: rtl/arb_counter.sv
// Up-counter with synchronous clear and enable; either saturates at MAX
// or wraps through zero.
module arb_counter #(
   parameter int               WIDTH    = 32,
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] MAX      = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !(SATURATE && (count == MAX))) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between an icache read port and a dcache
// read/write port, one word per grant, with starvation and timeout guards.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic      CLK,
   input  logic      n_rst,
   input  logic      iREN,
   input  word_t     iaddr,
   output word_t     iload,
   output logic      iwait,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output word_t     dload,
   output logic      dwait,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output word_t     icount,
   output word_t     dcount,
   output logic      err
);

   arb_state_t state, state_next;
   word_t      starve_cnt, to_cnt;
   logic       granted, req_live, done_ok, done_err, ack;

   always_comb begin
      granted  = (state != IDLE);
      req_live = (state == IGRANT) ? iREN : (dREN | dWEN);
      done_ok  = granted & req_live & (ramstate == ACCESS);
      // An ERROR response or an expired grant both end the transfer with a failed ack.
      done_err = granted & req_live & ~done_ok &
                 ((ramstate == ERROR) | (to_cnt == word_t'(TIMEOUT)));
      ack      = done_ok | done_err;
   end

   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE: begin
            if ((dREN | dWEN) && !(iREN && (starve_cnt == word_t'(STARVE_LIMIT))))
               state_next = DGRANT;
            else if (iREN)
               state_next = IGRANT;
         end
         default: begin
            if (!req_live || ack)
               state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      case (state)
         IGRANT: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            iwait   = ~ack;
            if (done_ok) iload = ramload;
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = ~ack;
            if (done_ok) dload = ramload;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         if (done_err) err <= 1'b1;
      end
   end

   arb_counter #(.WIDTH(32), .SATURATE(1'b1), .MAX(word_t'(STARVE_LIMIT))) u_starve (
      .clk   (CLK),
      .rst_n (n_rst),
      .en    ((state == DGRANT) & ack & iREN),
      .clr   (~iREN | ((state == IGRANT) & ack)),
      .count (starve_cnt)
   );

   arb_counter #(.WIDTH(32), .SATURATE(1'b1), .MAX(word_t'(TIMEOUT))) u_timeout (
      .clk   (CLK),
      .rst_n (n_rst),
      .en    (granted & ~ack),
      .clr   (state_next != state),
      .count (to_cnt)
   );

   arb_counter #(.WIDTH(32), .SATURATE(1'b0)) u_icount (
      .clk   (CLK),
      .rst_n (n_rst),
      .en    ((state == IGRANT) & done_ok),
      .clr   (1'b0),
      .count (icount)
   );

   arb_counter #(.WIDTH(32), .SATURATE(1'b0)) u_dcount (
      .clk   (CLK),
      .rst_n (n_rst),
      .en    ((state == DGRANT) & done_ok),
      .clr   (1'b0),
      .count (dcount)
   );

endmodule
